meal_request_sequencer: RTL and testbench

Upstream front-end for the mess credit system top level. Turns a raw, bouncy meal pushbutton plus user/action switches into clean, one-at-a-time meal requests. Buffers bursts in a small FIFO and dispatches each request only when the credit FSM is idle. Holds `action_type` and `user_select` stable until the FSM returns to idle, and tallies served and rejected transactions from `credit_ok`.

---
 rtl/mess_pkg.sv | 34 +++
 rtl/debounce_filter.sv | 60 ++++++
 rtl/meal_request_sequencer.sv | 158 +++++++++++++++
 tb/tb_meal_request_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mess_pkg.sv
// Shared definitions for the mess credit system: credit FSM state codes,
// action codes, request record layout and counter helpers.
package mess_pkg;

   localparam int CNT_W = 8;

   // Only the credit FSM states this front-end reacts to are named here.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_UPDATE = 3'd4;

   typedef enum logic [1:0] {
      ACT_MEAL  = 2'd0,
      ACT_SNACK = 2'd1,
      ACT_TOPUP = 2'd2,
      ACT_QUERY = 2'd3
   } action_e;

   typedef struct packed {
      logic    user;
      action_e action;
   } req_t;

   typedef enum logic [1:0] {
      D_IDLE,
      D_ISSUE,
      D_WAIT_START,
      D_WAIT_DONE
   } disp_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer plus stability counter; level_o follows the button only
// after DEBOUNCE_CYCLES identical samples. armed_o rises once a settled release is seen.
module debounce_filter #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_async_i,
   output logic level_o,
   output logic armed_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          armed_q, armed_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchronizer resets high so a button held through reset cannot arm the edge detector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= btn_async_i;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      armed_d = armed_q | (~level_q & ~sync2_q);
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
         armed_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign armed_o = armed_q;

endmodule

// File: rtl/meal_request_sequencer.sv
// Debounced meal button -> request FIFO -> one-at-a-time dispatch to the credit FSM.
// Requests wait in the FIFO while the FSM is busy; presses arriving when it is full are dropped.
module meal_request_sequencer
   import mess_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DEPTH           = 4,
   parameter int ACK_TIMEOUT     = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     meal_btn,
   input  logic                     user_sw,
   input  logic [1:0]               action_sw,
   input  logic [2:0]               fsm_state,
   input  logic                     credit_ok,
   output logic                     meal_request,
   output logic                     user_select,
   output logic [1:0]               action_type,
   output logic [$clog2(DEPTH):0]   queue_count,
   output logic                     overflow,
   output logic                     timeout,
   output logic [CNT_W-1:0]         served_count,
   output logic [CNT_W-1:0]         reject_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int QW = PW + 1;
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   logic btn_level, btn_armed, level_prev_q;
   logic push, pop, do_push, full, empty;
   req_t push_req;

   debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_async_i (meal_btn),
      .level_o     (btn_level),
      .armed_o     (btn_armed)
   );

   assign push     = btn_level & ~level_prev_q & btn_armed;
   assign push_req = '{user: user_sw, action: action_e'(action_sw)};

   req_t          mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [QW-1:0] count_q, count_d;
   logic          overflow_q;

   assign full    = (count_q == QW'(DEPTH));
   assign empty   = (count_q == '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push & (~full | pop);
   assign count_d = count_q + QW'(do_push) - QW'(pop);

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_prev_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
      end else begin
         level_prev_q <= btn_level;
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q      <= count_d;
         overflow_q   <= push & full & ~pop;
      end
   end

   disp_state_e      state_q, state_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   req_t             cur_q, cur_d;
   logic             counted_q, counted_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] served_q, served_d, reject_q, reject_d;

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      cur_d     = cur_q;
      counted_d = counted_q;
      timeout_d = 1'b0;
      served_d  = served_q;
      reject_d  = reject_q;
      pop       = 1'b0;
      case (state_q)
         D_IDLE: begin
            if (!empty && fsm_state == ST_IDLE) begin
               pop     = 1'b1;
               cur_d   = mem_q[rd_ptr_q];
               state_d = D_ISSUE;
            end
         end
         D_ISSUE: begin
            tmr_d     = '0;
            counted_d = 1'b0;
            state_d   = D_WAIT_START;
         end
         D_WAIT_START: begin
            if (fsm_state != ST_IDLE) begin
               state_d = D_WAIT_DONE;
            end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = D_IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         D_WAIT_DONE: begin
            // Only the first UPDATE cycle of a transaction is tallied.
            if (fsm_state == ST_UPDATE && !counted_q) begin
               counted_d = 1'b1;
               if (credit_ok) served_d = sat_inc(served_q);
               else           reject_d = sat_inc(reject_q);
            end
            if (fsm_state == ST_IDLE) state_d = D_IDLE;
         end
         default: state_d = D_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= D_IDLE;
         tmr_q     <= '0;
         cur_q     <= '0;
         counted_q <= 1'b0;
         timeout_q <= 1'b0;
         served_q  <= '0;
         reject_q  <= '0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         cur_q     <= cur_d;
         counted_q <= counted_d;
         timeout_q <= timeout_d;
         served_q  <= served_d;
         reject_q  <= reject_d;
      end
   end

   assign meal_request = (state_q == D_ISSUE);
   assign user_select  = cur_q.user;
   assign action_type  = cur_q.action;
   assign queue_count  = count_q;
   assign overflow     = overflow_q;
   assign timeout      = timeout_q;
   assign served_count = served_q;
   assign reject_count = reject_q;

endmodule

// File: tb/tb_meal_request_sequencer.sv
// Directed bench: a request-level model (queue of expected entries, transaction
// tracker, saturating tallies) checked against the DUT every cycle.
module tb_meal_request_sequencer;
   import mess_pkg::*;

   localparam int D     = 16;
   localparam int DEPTH = 4;
   localparam int ACK   = 32;

   localparam int M_RESP  = 0;
   localparam int M_STUCK = 1;
   localparam int M_HOLD  = 2;
   localparam int M_GRAB  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       meal_btn = 1'b0;
   logic       user_sw = 1'b0;
   logic [1:0] action_sw = 2'd0;
   logic [2:0] fsm_state = 3'd0;
   logic       credit_ok = 1'b0;

   logic       meal_request, user_select, overflow, timeout;
   logic [1:0] action_type;
   logic [2:0] queue_count;
   logic [7:0] served_count, reject_count;

   meal_request_sequencer #(
      .DEBOUNCE_CYCLES(D), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .meal_btn(meal_btn), .user_sw(user_sw),
      .action_sw(action_sw), .fsm_state(fsm_state), .credit_ok(credit_ok),
      .meal_request(meal_request), .user_select(user_select), .action_type(action_type),
      .queue_count(queue_count), .overflow(overflow), .timeout(timeout),
      .served_count(served_count), .reject_count(reject_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model state
   int m_q[$];
   int pend_due[$];
   int pend_val[$];
   int m_served = 0, m_reject = 0, held = 0;
   bit infl = 0, started = 0, counted = 0, cnt_pend = 0, cnt_cred = 0;
   int infl_t = 0, start_c = 0, cnt_due = 0, last_req = -100;
   int n_req = 0, n_ovf = 0, n_tmo = 0;
   int seen_act[$];
   int req_log[$];
   int tmo_log[$];
   int exp_ovf, exp_tmo, pv;

   int  mode = M_RESP;
   bit  cred = 1'b1;

   // Model credit FSM
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            M_HOLD:  fsm_state = ST_UPDATE;
            M_STUCK: fsm_state = ST_IDLE;
            M_GRAB: begin
               if (meal_request) fsm_state = 3'd1;
               else if (fsm_state != 3'd1) fsm_state = ST_IDLE;
            end
            default: begin
               if (meal_request) begin
                  step(1); fsm_state = 3'd1;
                  step(1); fsm_state = ST_UPDATE; credit_ok = cred;
                  step(2); fsm_state = ST_IDLE;
               end else begin
                  fsm_state = ST_IDLE;
               end
            end
         endcase
      end
   end

   // Compare process
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_meal_request", int'(meal_request), 0);
            chk("rst_queue_count", int'(queue_count), 0);
            chk("rst_request_fields", int'({user_select, action_type}), 0);
            chk("rst_overflow", int'(overflow), 0);
            chk("rst_timeout", int'(timeout), 0);
            chk("rst_served", int'(served_count), 0);
            chk("rst_reject", int'(reject_count), 0);
            m_q.delete(); pend_due.delete(); pend_val.delete();
            m_served = 0; m_reject = 0; held = 0;
            infl = 0; cnt_pend = 0; last_req = -100;
         end else begin
            if (cnt_pend && cyc == cnt_due) begin
               if (cnt_cred) m_served = (m_served < 255) ? m_served + 1 : 255;
               else          m_reject = (m_reject < 255) ? m_reject + 1 : 255;
               cnt_pend = 0;
            end
            if (meal_request) begin
               n_req++;
               chk("req_while_busy", int'(infl), 0);
               chk("req_spacing_ok", int'(cyc - last_req >= 3), 1);
               chk("req_queue_nonempty", int'(m_q.size() != 0), 1);
               if (m_q.size() != 0) begin
                  chk("req_order", int'({user_select, action_type}), m_q[0]);
                  held = m_q.pop_front();
               end
               seen_act.push_back(int'(action_type));
               req_log.push_back(cyc);
               infl = 1; started = 0; counted = 0; infl_t = cyc; last_req = cyc;
            end
            exp_ovf = 0;
            while (pend_due.size() != 0 && pend_due[0] <= cyc) begin
               pv = pend_val.pop_front();
               void'(pend_due.pop_front());
               if (m_q.size() < DEPTH) m_q.push_back(pv);
               else exp_ovf = 1;
            end
            chk("overflow", int'(overflow), exp_ovf);
            if (overflow) n_ovf++;
            chk("queue_count", int'(queue_count), m_q.size());
            chk("held_request", int'({user_select, action_type}), held);
            // Abandon after ISSUE plus ACK cycles of waiting; pulse lands one cycle later.
            exp_tmo = int'(infl && !started && (cyc == infl_t + ACK + 1));
            chk("timeout", int'(timeout), exp_tmo);
            if (timeout) begin n_tmo++; tmo_log.push_back(cyc); end
            if (exp_tmo != 0) begin
               infl = 0;
            end else if (infl && !started && cyc > infl_t && fsm_state != ST_IDLE) begin
               started = 1; start_c = cyc;
            end else if (infl && started && cyc > start_c) begin
               if (fsm_state == ST_UPDATE && !counted) begin
                  counted = 1; cnt_pend = 1; cnt_due = cyc + 1; cnt_cred = credit_ok;
               end
               if (fsm_state == ST_IDLE) infl = 0;
            end
            chk("served_count", int'(served_count), m_served);
            chk("reject_count", int'(reject_count), m_reject);
         end
      end
   end

   // Raw input settles high now (just after edge n); push visible at cycle n+D+3.
   task automatic schedule_push();
      pend_due.push_back(cyc + D + 3);
      pend_val.push_back(int'({user_sw, action_sw}));
   endtask

   task automatic press_clean();
      meal_btn = 1'b1;
      schedule_push();
      step(D + 8);
      meal_btn = 1'b0;
      step(D + 8);
   endtask

   task automatic press_bouncy();
      for (int i = 0; i < 5; i++) begin
         meal_btn = 1'b1; step(3);
         meal_btn = 1'b0; step(3);
      end
      meal_btn = 1'b1;
      schedule_push();
      step(40);
      meal_btn = 1'b0;
      step(D + 8);
   endtask

   int base, r0, t0, req_before, tmo_before;
   int exp_ord[4] = '{1, 2, 3, 0};

   initial begin
      rst_n = 1'b0;
      step(3);
      chk("init_queue_count", int'(queue_count), 0);
      chk("init_served", int'(served_count), 0);
      rst_n = 1'b1;
      step(5);

      // Bouncy press, approved credit
      user_sw = 1'b1; action_sw = 2'd2; cred = 1'b1;
      press_bouncy();
      step(10);
      chk("t1_requests", n_req, 1);
      chk("t1_served", int'(served_count), 1);

      // Rejected credit
      user_sw = 1'b0; action_sw = 2'd3; cred = 1'b0;
      press_clean();
      step(10);
      chk("t3_served", int'(served_count), 1);
      chk("t3_reject", int'(reject_count), 1);

      // Burst while the credit FSM is busy
      mode = M_HOLD; cred = 1'b1;
      step(2);
      for (int i = 0; i < 5; i++) begin
         action_sw = (i == 4) ? 2'd1 : 2'(exp_ord[i]);
         press_clean();
      end
      chk("t2_overflow_pulses", n_ovf, 1);
      chk("t2_queue_full", int'(queue_count), 4);
      base = seen_act.size();
      mode = M_RESP;
      step(40);
      for (int i = 0; i < 4; i++) chk("t2_dispatch_order", seen_act[base + i], exp_ord[i]);
      chk("t2_queue_drained", int'(queue_count), 0);
      chk("t2_served", int'(served_count), 5);

      // Credit FSM never acknowledges
      mode = M_HOLD;
      step(2);
      action_sw = 2'd1; press_clean();
      action_sw = 2'd2; press_clean();
      r0 = req_log.size(); t0 = tmo_log.size(); tmo_before = n_tmo;
      mode = M_STUCK;
      step(90);
      chk("t4_timeouts", n_tmo - tmo_before, 2);
      chk("t4_timeout_latency", tmo_log[t0] - req_log[r0], ACK + 1);
      chk("t4_next_dispatch", req_log[r0 + 1] - tmo_log[t0], 1);
      chk("t4_second_action", seen_act[r0 + 1], 2);

      // Served counter saturation
      mode = M_RESP; cred = 1'b1; action_sw = 2'd0;
      step(4);
      for (int i = 0; i < 249; i++) press_clean();
      chk("t5_served_254", int'(served_count), 254);
      for (int i = 0; i < 3; i++) press_clean();
      chk("t5_served_saturated", int'(served_count), 255);

      // Reset mid-transaction, button held through reset release
      mode = M_HOLD;
      step(2);
      for (int i = 0; i < 3; i++) press_clean();
      mode = M_GRAB;
      step(10);
      chk("t6_queued", int'(queue_count), 2);
      meal_btn = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_meal_request", int'(meal_request), 0);
      chk("t6_rst_queue_count", int'(queue_count), 0);
      chk("t6_rst_action", int'(action_type), 0);
      chk("t6_rst_served", int'(served_count), 0);
      chk("t6_rst_reject", int'(reject_count), 0);
      step(3);
      mode = M_RESP;
      rst_n = 1'b1;
      req_before = n_req;
      step(60);
      chk("t6_no_push_while_held", int'(queue_count), 0);
      chk("t6_no_request_while_held", n_req - req_before, 0);
      meal_btn = 1'b0;
      step(D + 8);
      chk("t6_no_request_after_release", n_req - req_before, 0);
      action_sw = 2'd3;
      press_clean();
      step(10);
      chk("t6_request_after_new_press", n_req - req_before, 1);
      chk("t6_served_after_reset", int'(served_count), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
